// File: rtl/hc_pkg.sv
// Shared hypercube path definitions: default geometry, sequencer state
// encoding and the width helpers also used by the router.
package hc_pkg;

    localparam int HC_DIM_DEF     = 4;
    localparam int HC_MAX_GRP_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } hc_state_e;

    function automatic int hc_dim_w(input int dim);
        return (dim > 2) ? $clog2(dim) : 1;
    endfunction

    function automatic int hc_len_w(input int dim);
        return $clog2(dim + 1);
    endfunction

    function automatic int hc_grp_w(input int max_grp);
        return (max_grp > 1) ? $clog2(max_grp + 1) : 1;
    endfunction

endpackage

// File: rtl/hc_ctz.sv
// Count trailing zeros of a (DIM+1)-bit value; results beyond DIM-1
// (including an all-zero input) saturate to DIM-1.
module hc_ctz
    import hc_pkg::*;
#(
    parameter  int DIM = HC_DIM_DEF,
    localparam int DW  = hc_dim_w(DIM)
) (
    input  logic [DIM:0]  val,
    output logic [DW-1:0] ctz
);

    // Downward scan so the lowest set bit is the last one to win.
    always_comb begin
        ctz = DW'(DIM - 1);
        for (int i = DIM - 1; i >= 0; i--) begin
            ctz = val[i] ? DW'(i) : ctz;
        end
    end

endmodule

// File: rtl/hc_path_seq.sv
// Hypercube path sequencer: expands a subcube-group command into a stream of
// dimension-traversal steps with a valid/ready handshake.
module hc_path_seq
    import hc_pkg::*;
#(
    parameter  int DIM     = HC_DIM_DEF,
    parameter  int MAX_GRP = HC_MAX_GRP_DEF,
    localparam int DW      = hc_dim_w(DIM),
    localparam int LW      = hc_len_w(DIM),
    localparam int GW      = hc_grp_w(MAX_GRP)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [GW-1:0]         cmd_grp_cnt,
    input  logic [MAX_GRP*LW-1:0] cmd_len,
    input  logic [MAX_GRP*DW-1:0] cmd_base,
    input  logic [MAX_GRP*DW-1:0] cmd_exit,
    output logic                  step_valid,
    input  logic                  step_ready,
    output logic [DW-1:0]         step_dim,
    output logic [GW-1:0]         step_grp,
    output logic                  step_last,
    output logic                  busy,
    output logic                  ovf
);

    localparam int CW = DIM + 1;
    localparam int TW = DIM + 3;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {DIM{1'b0}}};
    localparam logic [DW:0]   DIM_V    = (DW + 1)'(DIM);

    hc_state_e             state_q, state_d;
    logic [GW-1:0]         grp_cnt_q, grp_cnt_d;
    logic [MAX_GRP*LW-1:0] len_q, len_d;
    logic [MAX_GRP*DW-1:0] base_q, base_d, exit_q, exit_d;
    logic [GW-1:0]         ptr_grp_q, ptr_grp_d;
    logic [CW-1:0]         ptr_idx_q, ptr_idx_d, cnt_q, cnt_d;
    logic                  step_valid_q, step_valid_d;
    logic [DW-1:0]         step_dim_q, step_dim_d;
    logic [GW-1:0]         step_grp_q, step_grp_d;
    logic                  step_last_q, step_last_d;
    logic                  ovf_q, ovf_d;

    logic                  cmd_ready_s, accept_s, advance_s, load_s;
    logic [GW-1:0]         src_cnt_s;
    logic [MAX_GRP*LW-1:0] src_len_s;
    logic [MAX_GRP*DW-1:0] src_base_s, src_exit_s;
    logic [CW-1:0]         lim_s [MAX_GRP];
    logic [MAX_GRP-1:0]    live_s;
    logic [TW-1:0]         total_s;
    logic [CW-1:0]         cur_lim_s, nxt_lim_s, nxt_idx_s, nxt_cnt_s, ctz_in_s;
    logic                  cand_found_s, nxt_found_s, cand_hit_s;
    logic [GW-1:0]         cand_grp_s, nxt_grp_s;
    logic [CW-1:0]         cand_idx_s;
    logic [DW-1:0]         nxt_base_s, nxt_exit_s, ctz_s, nxt_dim_s;
    logic [DW:0]           sum_s;
    logic                  nxt_last_s, nxt_trunc_s;

    assign cmd_ready_s = rst_n && (state_q == ST_IDLE) && !flush;
    assign accept_s    = cmd_valid && cmd_ready_s;
    assign advance_s   = (state_q == ST_EMIT) && step_valid_q && step_ready && !step_last_q;
    assign load_s      = (accept_s || advance_s) && nxt_found_s && !flush;

    // The first step is derived from the live command inputs, later ones from the captured copy.
    always_comb begin
        src_cnt_s  = accept_s ? cmd_grp_cnt : grp_cnt_q;
        src_len_s  = accept_s ? cmd_len     : len_q;
        src_base_s = accept_s ? cmd_base    : base_q;
        src_exit_s = accept_s ? cmd_exit    : exit_q;
        total_s    = {TW{1'b0}};
        for (int g = 0; g < MAX_GRP; g++) begin
            lim_s[g]  = (CW'(1) << src_len_s[g*LW +: LW]) - CW'(1);
            live_s[g] = (GW'(g) < src_cnt_s) && (src_len_s[g*LW +: LW] != {LW{1'b0}});
            total_s   = total_s + (live_s[g] ? (TW'(lim_s[g]) + ((g == 0) ? TW'(1) : TW'(0)))
                                             : {TW{1'b0}});
        end
    end

    // Locate the next step: stay inside the current group or jump to the next live one.
    always_comb begin
        cur_lim_s    = {CW{1'b0}};
        cand_found_s = 1'b0;
        cand_hit_s   = 1'b0;
        cand_grp_s   = {GW{1'b0}};
        cand_idx_s   = {CW{1'b0}};
        for (int g = MAX_GRP - 1; g >= 0; g--) begin
            cur_lim_s    = (GW'(g) == ptr_grp_q) ? lim_s[g] : cur_lim_s;
            cand_hit_s   = live_s[g] && (accept_s || (GW'(g) > ptr_grp_q));
            cand_found_s = cand_found_s | cand_hit_s;
            cand_grp_s   = cand_hit_s ? GW'(g) : cand_grp_s;
            cand_idx_s   = cand_hit_s ? ((g == 0) ? {CW{1'b0}} : CW'(1)) : cand_idx_s;
        end
        if (!accept_s && (ptr_idx_q < cur_lim_s)) begin
            nxt_found_s = 1'b1;
            nxt_grp_s   = ptr_grp_q;
            nxt_idx_s   = ptr_idx_q + CW'(1);
        end else begin
            nxt_found_s = cand_found_s;
            nxt_grp_s   = cand_grp_s;
            nxt_idx_s   = cand_idx_s;
        end
    end

    assign ctz_in_s = nxt_idx_s + CW'(1);

    hc_ctz #(.DIM(DIM)) u_ctz (
        .val (ctz_in_s),
        .ctz (ctz_s)
    );

    // Dimension, last flag and truncation for the step about to be presented.
    always_comb begin
        nxt_lim_s  = {CW{1'b0}};
        nxt_base_s = {DW{1'b0}};
        nxt_exit_s = {DW{1'b0}};
        for (int g = 0; g < MAX_GRP; g++) begin
            nxt_lim_s  = (GW'(g) == nxt_grp_s) ? lim_s[g]                : nxt_lim_s;
            nxt_base_s = (GW'(g) == nxt_grp_s) ? src_base_s[g*DW +: DW] : nxt_base_s;
            nxt_exit_s = (GW'(g) == nxt_grp_s) ? src_exit_s[g*DW +: DW] : nxt_exit_s;
        end
        sum_s = {1'b0, nxt_base_s} + {1'b0, ctz_s};
        if (nxt_idx_s == nxt_lim_s) begin
            nxt_dim_s = nxt_exit_s;
        end else if (nxt_grp_s == {GW{1'b0}}) begin
            nxt_dim_s = ctz_s;
        end else if (sum_s >= DIM_V) begin
            nxt_dim_s = {DW{1'b0}};
        end else begin
            nxt_dim_s = sum_s[DW-1:0];
        end
        nxt_cnt_s   = accept_s ? CW'(1) : (cnt_q + CW'(1));
        nxt_last_s  = (TW'(nxt_cnt_s) == total_s) || (nxt_cnt_s == FULL_CNT);
        nxt_trunc_s = (nxt_cnt_s == FULL_CNT) && (total_s > TW'(FULL_CNT));
    end

    // Next-state logic for the FSM, command copy and presented step.
    always_comb begin
        case (state_q)
            ST_IDLE: state_d = accept_s ? ST_EMIT : ST_IDLE;
            ST_EMIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (!step_valid_q || (step_ready && step_last_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept_s) begin
            grp_cnt_d = cmd_grp_cnt;
            len_d     = cmd_len;
            base_d    = cmd_base;
            exit_d    = cmd_exit;
        end else begin
            grp_cnt_d = grp_cnt_q;
            len_d     = len_q;
            base_d    = base_q;
            exit_d    = exit_q;
        end

        step_dim_d  = step_dim_q;
        step_grp_d  = step_grp_q;
        step_last_d = step_last_q;
        ptr_grp_d   = ptr_grp_q;
        ptr_idx_d   = ptr_idx_q;
        cnt_d       = cnt_q;
        if (load_s) begin
            step_valid_d = 1'b1;
            step_dim_d   = nxt_dim_s;
            step_grp_d   = nxt_grp_s;
            step_last_d  = nxt_last_s;
            ptr_grp_d    = nxt_grp_s;
            ptr_idx_d    = nxt_idx_s;
            cnt_d        = nxt_cnt_s;
        end else if (flush || ((state_q == ST_EMIT) && step_valid_q && step_ready)) begin
            step_valid_d = 1'b0;
        end else begin
            step_valid_d = step_valid_q;
        end

        if (load_s && nxt_trunc_s) begin
            ovf_d = 1'b1;
        end else if (accept_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grp_cnt_q    <= {GW{1'b0}};
            len_q        <= {(MAX_GRP*LW){1'b0}};
            base_q       <= {(MAX_GRP*DW){1'b0}};
            exit_q       <= {(MAX_GRP*DW){1'b0}};
            ptr_grp_q    <= {GW{1'b0}};
            ptr_idx_q    <= {CW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            step_valid_q <= 1'b0;
            step_dim_q   <= {DW{1'b0}};
            step_grp_q   <= {GW{1'b0}};
            step_last_q  <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grp_cnt_q    <= grp_cnt_d;
            len_q        <= len_d;
            base_q       <= base_d;
            exit_q       <= exit_d;
            ptr_grp_q    <= ptr_grp_d;
            ptr_idx_q    <= ptr_idx_d;
            cnt_q        <= cnt_d;
            step_valid_q <= step_valid_d;
            step_dim_q   <= step_dim_d;
            step_grp_q   <= step_grp_d;
            step_last_q  <= step_last_d;
            ovf_q        <= ovf_d;
        end
    end

    assign cmd_ready  = cmd_ready_s;
    assign step_valid = step_valid_q;
    assign step_dim   = step_dim_q;
    assign step_grp   = step_grp_q;
    assign step_last  = step_last_q;
    assign busy       = (state_q != ST_IDLE);
    assign ovf        = ovf_q;

endmodule

// File: doc/hc_path_seq.md
HC_PATH_SEQ -- requirements
Module: hc_path_seq

Interface
REQ-001 Parameter DIM, default 4, hypercube dimension count (2..8).
REQ-002 Parameter MAX_GRP, default 3, maximum subcube groups per command (1..4).
REQ-003 Derived widths: DW=$clog2(DIM) dim index; LW=$clog2(DIM+1) group length; GW=$clog2(MAX_GRP+1) group count.
REQ-004 One clock and a synchronous, active-low reset. Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  abort current path, return to IDLE.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_grp_cnt  in  GW  number of groups used (0..MAX_GRP).
- cmd_len  in  MAX_GRP*LW  group g length L_g, slice g.
- cmd_base  in  MAX_GRP*DW  group g base dimension, slice g.
- cmd_exit  in  MAX_GRP*DW  group g exit dimension, slice g.
- step_valid  out  1  step_dim valid.
- step_ready  in  1  consumer accepts step.
- step_dim  out  DW  dimension to traverse.
- step_grp  out  GW  group index of current step.
- step_last  out  1  final step of path.
- busy  out  1  high outside IDLE.
- ovf  out  1  sticky: last path truncated at 2^DIM steps; cleared on next accept.

Function
REQ-005 FSM states IDLE, EMIT, DONE; IDLE->EMIT on accept, EMIT->DONE on accepted step_last, DONE->IDLE next cycle.
REQ-006 cmd_ready = (state==IDLE) && !flush; all cmd_* captured into registers on accept.
REQ-007 Group g index i runs 0..2^L_g-1 for g=0, 1..2^L_g-1 for g>0; groups with L_g=0 or g>=cmd_grp_cnt emit nothing.
REQ-008 Step at index i<2^L_g-1: g=0 dim=ctz(i+1); g>0 dim=base_g+ctz(i+1), replaced by 0 if sum>=DIM (no wrap); cmd_base ignored for g=0.
REQ-009 Step at index i=2^L_g-1 emits exit_g.
REQ-010 step_valid rises the cycle after accept; one step per cycle while step_ready high; no bubbles between groups.
REQ-011 step_dim, step_grp, step_last held stable while step_valid && !step_ready.
REQ-012 step_last asserted on the final step of the last non-empty group, or on the 2^DIM-th step if total exceeds 2^DIM (then ovf=1, remainder dropped).
REQ-013 Command with no non-empty groups: accepted, no steps emitted, EMIT->DONE directly, ovf=0.
REQ-014 flush: next cycle state=IDLE, step_valid=0, pending steps discarded, ovf unchanged; flush wins over simultaneous cmd_valid and step handshake.
REQ-015 Step counter width DIM+1; index arithmetic unsigned, no truncation before comparison.

Reset
REQ-016 rst_n low at clock edge: state=IDLE, step_valid=0, step_dim=0, step_grp=0, step_last=0, busy=0, ovf=0, command registers 0.
REQ-017 cmd_ready=0 while rst_n low; 1 the first cycle after release.
REQ-018 Reset mid-path drops the path with no further step_valid.

Structure
REQ-019 Package hc_pkg holds DIM default, FSM state enum, width helpers shared with the router.
REQ-020 Sub-module hc_ctz: combinational count-trailing-zeros of (DIM+1)-bit input, output saturated to DIM-1.

Verification
REQ-021 DIM=4, grp_cnt=1, L0=4, exit0=3, step_ready=1 -> 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3 on consecutive cycles, step_last on 16th, ovf=0.
REQ-022 grp_cnt=2, L0=2 exit0=2, L1=2 base1=1 exit1=3 -> 0,1,0,2,2,1,3; step_grp 0,0,0,0,1,1,1; step_last on 7th.
REQ-023 grp_cnt=2, L0=1 exit0=1, L1=2 base1=3 exit1=2 -> 0,1,0,3,2 (3+1 saturates to 0).
REQ-024 REQ-021 stimulus, step_ready low cycles 3-5 -> step_dim=0 held (step 3), sequence unchanged, total 19 cycles.
REQ-025 grp_cnt=2, L0=4, L1=2 -> 16 steps, step_last on 16th, ovf=1; next command clears ovf.
REQ-026 flush (then rst_n low) at step 5 of REQ-021 -> step_valid=0 next cycle, cmd_ready=1 following cycle, new command starts at step_dim=0.
